// File: rtl/uart_pkg.sv
// uart_pkg: shared limits, field widths and the reset-divisor helper used by
// uart_baud_gen, its interface and its fractional divider.
package uart_pkg;

  // Legal range of sample ticks per bit.
  localparam int OVERSAMPLE_MIN = 2;
  localparam int OVERSAMPLE_MAX = 64;

  // Fractional divisor part is expressed in sixteenths.
  localparam int FRAC_W = 4;

  // Bit counter must hold OVERSAMPLE_MAX-1.
  localparam int BIT_CNT_W = $clog2(OVERSAMPLE_MAX);

  // Clocks per sample tick for the reset baud rate, truncated.
  function automatic longint unsigned calc_div0(input longint unsigned clk_freq_hz,
                                                input longint unsigned baud,
                                                input longint unsigned oversample);
    return clk_freq_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and strobe signals between a UART and its baud
// generator. The UART side uses the master modport, the generator the slave.
interface uart_baud_gen_if #(
  parameter int DIV_WIDTH = 16
);
  import uart_pkg::*;

  logic                 i_enable;
  logic                 i_sync_clr;
  logic                 i_div_wr;
  logic [DIV_WIDTH-1:0] i_div;
  logic [FRAC_W-1:0]    i_frac;
  logic                 o_tick;
  logic                 o_bit_tick;
  logic                 o_div_ack;
  logic                 o_div_err;
  logic [DIV_WIDTH-1:0] o_div;

  modport master (
    output i_enable, i_sync_clr, i_div_wr, i_div, i_frac,
    input  o_tick, o_bit_tick, o_div_ack, o_div_err, o_div
  );

  modport slave (
    input  i_enable, i_sync_clr, i_div_wr, i_div, i_frac,
    output o_tick, o_bit_tick, o_div_ack, o_div_err, o_div
  );

endinterface

// File: rtl/uart_frac_div.sv
// uart_frac_div: divisor counter producing the sample-tick wrap strobe.
// With UART_BAUD_FRAC_EN defined, a 4-bit accumulator adds the fractional
// divisor on every wrap and stretches the following period by one clock on
// carry-out; otherwise i_frac is ignored and every period is i_div clocks.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_sync_clr,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic [FRAC_W-1:0]    i_frac,
  output logic                 o_wrap
);

  localparam int PW = DIV_WIDTH + 1;

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        last_cnt;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [FRAC_W:0]   acc_sum;

  assign last_cnt = PW'(i_div) + PW'(extra_q) - PW'(1);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, i_frac};
`else
  logic unused_frac;

  assign unused_frac = ^i_frac;
  assign last_cnt    = PW'(i_div) - PW'(1);
`endif

  // '>=' rather than '==' so a smaller divisor applied while the counter is
  // held above it still wraps on the next enabled clock.
  assign o_wrap = i_enable && !i_sync_clr && (PW'(cnt_q) >= last_cnt);

  // Divisor counter: clear on sync, wrap at period end, else count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_sync_clr || o_wrap) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Divisor counter register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  // Fractional accumulator: a carry lengthens the next period; sync drops it.
  always_comb begin
    acc_d   = acc_q;
    extra_d = extra_q;
    if (i_sync_clr) begin
      extra_d = 1'b0;
    end else if (o_wrap) begin
      acc_d   = acc_sum[FRAC_W-1:0];
      extra_d = acc_sum[FRAC_W];
    end
  end

  // Fractional accumulator register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q   <= '0;
      extra_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      extra_q <= extra_d;
    end
  end
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: UART oversample and bit tick generator with a glitch-free
// run-time divisor change handshake. The divisor counter lives in
// uart_frac_div; the bit counter and divisor handshake live here.
// Optional feature: define UART_BAUD_FRAC_EN to enable fractional division.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int DEFAULT_BAUD = 19200,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_baud_gen_if.slave bus
);

  localparam longint unsigned DIV0_L  = calc_div0(longint'(CLK_FREQ_HZ),
                                                  longint'(DEFAULT_BAUD),
                                                  longint'(OVERSAMPLE));
  localparam longint unsigned DIV_MAX = (longint'(1) << DIV_WIDTH) - 1;
  localparam logic [DIV_WIDTH-1:0] DIV0     = DIV_WIDTH'(DIV0_L);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(OVERSAMPLE - 1);

  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
    $error("uart_baud_gen: OVERSAMPLE must lie in 2..64");
  end
  if (DIV0_L < 1 || DIV0_L > DIV_MAX) begin : g_bad_div0
    $error("uart_baud_gen: reset divisor is zero or does not fit DIV_WIDTH");
  end

  logic                 wrap;
  logic                 div_zero;
  logic                 apply;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [FRAC_W-1:0]    frac_act_q, frac_act_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic [FRAC_W-1:0]    pend_frac_q, pend_frac_d;
  logic                 pend_q, pend_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 tick_q, tick_d;
  logic                 bit_tick_q, bit_tick_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  uart_frac_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_frac_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (bus.i_enable),
    .i_sync_clr (bus.i_sync_clr),
    .i_div      (div_act_q),
    .i_frac     (frac_act_q),
    .o_wrap     (wrap)
  );

  // A pending divisor swaps in only at a period boundary, or at once when the
  // counter is idle or being cleared, so no tick period is ever truncated.
  assign div_zero = (bus.i_div == '0);
  assign apply    = pend_q && (wrap || !bus.i_enable || bus.i_sync_clr);

  // Bit counter, divisor handshake and next values of the output strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    bit_cnt_d   = bit_cnt_q;
    div_act_d   = div_act_q;
    frac_act_d  = frac_act_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    tick_d      = wrap;
    bit_tick_d  = 1'b0;
    ack_d       = apply;
    err_d       = bus.i_div_wr && div_zero;

    if (bus.i_sync_clr) begin
      bit_cnt_d = '0;
    end else if (wrap) begin
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d  = '0;
        bit_tick_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end

    if (apply) begin
      div_act_d  = pend_div_q;
      frac_act_d = pend_frac_q;
      pend_d     = 1'b0;
    end

    // A write in the same cycle as an apply wins the pending slot.
    if (bus.i_div_wr && !div_zero) begin
      pend_div_d  = bus.i_div;
      pend_frac_d = bus.i_frac;
      pend_d      = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt_q   <= '0;
      div_act_q   <= DIV0;
      frac_act_q  <= '0;
      pend_q      <= 1'b0;
      // NOTE: the pending data is reset along with its flag so the register never holds X, even though pend_q alone guards its use.
      pend_div_q  <= '0;
      pend_frac_q <= '0;
      tick_q      <= 1'b0;
      bit_tick_q  <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge value of every other flop.
      bit_cnt_q   <= bit_cnt_d;
      div_act_q   <= div_act_d;
      frac_act_q  <= frac_act_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      tick_q      <= tick_d;
      bit_tick_q  <= bit_tick_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_tick     = tick_q;
  assign bus.o_bit_tick = bit_tick_q;
  assign bus.o_div_ack  = ack_q;
  assign bus.o_div_err  = err_q;
  assign bus.o_div      = div_act_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed scenarios plus randomized traffic, every cycle
// compared against a period/phase reference model of the baud generator.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int CLK_FREQ_HZ  = 50000000;
  localparam int DEFAULT_BAUD = 19200;
  localparam int OVERSAMPLE   = 16;
  localparam int DIV_WIDTH    = 16;
  localparam int DIV0         = 162;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  uart_baud_gen #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .DEFAULT_BAUD (DEFAULT_BAUD),
    .OVERSAMPLE   (OVERSAMPLE),
    .DIV_WIDTH    (DIV_WIDTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed tick bookkeeping.
  int last_tick_cyc = 0, last_gap = 0, n_ticks = 0;
  int last_bit_cyc = 0, last_bit_gap = 0, n_bits = 0;
  int n_acks = 0;

  // Reference model: clocks elapsed in the current period, ticks since the
  // last bit boundary, active/pending divisor and the fraction sum.
  int m_elapsed, m_ticks, m_div, m_frac, m_acc, m_extra;
  int m_pend, m_pend_div, m_pend_frac;
  bit e_tick, e_bit, e_ack, e_err;
  int e_div;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_ticks = 0; m_div = DIV0; m_frac = 0; m_acc = 0; m_extra = 0;
    m_pend = 0; m_pend_div = 0; m_pend_frac = 0;
  endtask

  // One rising edge of the reference model with the inputs seen at that edge.
  task automatic model_edge(input bit en, input bit clr, input bit wr, input int d, input int f);
    int  per;
    bit  wrap;
    bit  apply;
    per   = m_div + m_extra;
    wrap  = en && !clr && (m_elapsed >= per - 1);
    apply = (m_pend != 0) && (wrap || !en || clr);
    e_tick = wrap;
    e_bit  = wrap && (m_ticks == OVERSAMPLE - 1);
    e_ack  = apply;
    e_err  = wr && (d == 0);
    if (clr) begin
      m_elapsed = 0; m_ticks = 0; m_extra = 0;
    end else if (wrap) begin
      m_elapsed = 0;
      m_ticks   = (m_ticks + 1) % OVERSAMPLE;
      if (FRAC_ON) begin
        m_extra = ((m_acc + m_frac) >= 16) ? 1 : 0;
        m_acc   = (m_acc + m_frac) % 16;
      end
    end else if (en) begin
      m_elapsed++;
    end
    if (apply) begin
      m_div = m_pend_div; m_frac = m_pend_frac; m_pend = 0;
    end
    if (wr && d != 0) begin
      m_pend_div = d; m_pend_frac = f; m_pend = 1;
    end
    e_div = m_div;
  endtask

  // Drive one cycle of inputs (called at a falling edge), then compare at the next falling edge.
  task automatic step(input bit en, input bit clr, input bit wr, input int d, input int f);
    bus.i_enable   = en;
    bus.i_sync_clr = clr;
    bus.i_div_wr   = wr;
    bus.i_div      = DIV_WIDTH'(d);
    bus.i_frac     = FRAC_W'(f);
    @(posedge clk);
    cyc++;
    model_edge(en, clr, wr, d, f);
    @(negedge clk);
    check("tick", bus.o_tick, e_tick);
    check("bit_tick", bus.o_bit_tick, e_bit);
    check("div_ack", bus.o_div_ack, e_ack);
    check("div_err", bus.o_div_err, e_err);
    check("div", bus.o_div, e_div);
    if (bus.o_tick === 1'b1) begin
      last_gap = cyc - last_tick_cyc; last_tick_cyc = cyc; n_ticks++;
    end
    if (bus.o_bit_tick === 1'b1) begin
      last_bit_gap = cyc - last_bit_cyc; last_bit_cyc = cyc; n_bits++;
    end
    if (bus.o_div_ack === 1'b1) n_acks++;
  endtask

  task automatic run_to_tick(input string tag, input int budget);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      n++;
      seen = (bus.o_tick === 1'b1);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_to_bit(input string tag, input int budget);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      n++;
      seen = (bus.o_bit_tick === 1'b1);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int t0;
    int clr_cyc;
    int ticks_before;
    int gaps[8];
    bit acked;

    bus.i_enable = 1'b0; bus.i_sync_clr = 1'b0; bus.i_div_wr = 1'b0;
    bus.i_div = '0; bus.i_frac = '0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tick", bus.o_tick, 1'b0);
    check("rst_bit_tick", bus.o_bit_tick, 1'b0);
    check("rst_ack", bus.o_div_ack, 1'b0);
    check("rst_err", bus.o_div_err, 1'b0);
    check("rst_div", bus.o_div, DIV0);
    rst_n = 1'b1;

    // Free running at the reset divisor: 162-clock ticks, 2592-clock bits.
    repeat (5300) step(1'b1, 1'b0, 1'b0, 0, 0);
    check("tick_gap_162", last_gap, 162);
    check("bit_gap_2592", last_bit_gap, 2592);
    check("tick_count", n_ticks, 32);
    check("bit_count", n_bits, 2);

    // Zero divisor write is rejected.
    repeat (20) step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 0, 0);
    check("zero_err_pulse", bus.o_div_err, 1'b1);
    run_to_tick("zero_t1", 400);
    run_to_tick("zero_t2", 400);
    check("zero_gap", last_gap, 162);
    check("zero_div", bus.o_div, DIV0);

    // Sync clear 40 clocks after a tick.
    run_to_tick("clr_align", 400);
    repeat (39) step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    check("clr_no_tick", bus.o_tick, 1'b0);
    clr_cyc = cyc;
    run_to_tick("clr_next", 400);
    check("clr_gap", cyc - clr_cyc, 162);
    run_to_bit("clr_bit", 3000);
    check("clr_bit_gap", cyc - clr_cyc, 2592);

    // Enable low for 100 clocks mid-period.
    run_to_tick("en_align", 400);
    t0 = cyc;
    ticks_before = n_ticks;
    repeat (50) step(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (100) step(1'b0, 1'b0, 1'b0, 0, 0);
    check("en_no_ticks", n_ticks, ticks_before);
    run_to_tick("en_resume", 400);
    check("en_gap", cyc - t0, 262);

    // Divisor 5 written mid-period: old period completes, then 5-clock ticks.
    run_to_tick("wr5_align", 400);
    t0 = cyc;
    repeat (30) step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 5, 0);
    run_to_tick("wr5_apply", 400);
    check("wr5_old_gap", cyc - t0, 162);
    check("wr5_ack_with_tick", bus.o_div_ack, 1'b1);
    check("wr5_div", bus.o_div, 5);
    for (int i = 0; i < 3; i++) begin
      run_to_tick("wr5_run", 20);
      check("wr5_gap", last_gap, 5);
    end

    // Fractional divisor 5 + 8/16.
    step(1'b1, 1'b0, 1'b1, 5, 8);
    acked = 1'b0;
    for (int i = 0; i < 4 && !acked; i++) begin
      run_to_tick("frac_apply", 20);
      acked = (bus.o_div_ack === 1'b1);
    end
    check("frac_acked", acked, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_to_tick("frac_run", 20);
      gaps[i] = last_gap;
    end
    for (int i = 1; i < 7; i++) begin
      if (FRAC_ON) check("frac_pair", gaps[i] + gaps[i+1], 11);
      else         check("frac_off_gap", gaps[i], 5);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit en, clr, wr;
      int d, f;
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 63) == 0);
      wr  = ($urandom_range(0, 31) == 0);
      d   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      f   = int'($urandom_range(0, 15));
      step(en, clr, wr, d, f);
    end

    // Reset while a request is pending discards it without an ack.
    step(1'b1, 1'b0, 1'b1, 9, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_div", bus.o_div, DIV0);
    check("midrst_ack", bus.o_div_ack, 1'b0);
    check("midrst_tick", bus.o_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_acks = 0;
    repeat (400) step(1'b1, 1'b0, 1'b0, 0, 0);
    check("midrst_no_ack", n_acks, 0);
    check("midrst_div_kept", bus.o_div, DIV0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
